// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and datamem: queues pipeline stores, retires them
// in order on cycles without a memory request, and forwards buffered data to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [AW-1:0] Addr,
    input  logic [DW-1:0] Wdata,
    output logic          Stall,
    output logic          MemWriteOut,
    output logic          MemReadOut,
    output logic [AW-1:0] AddrOut,
    output logic [DW-1:0] WdataOut,
    output logic          FwdHit,
    output logic [DW-1:0] FwdData,
    output logic          Empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          fwd_hit_q, fwd_hit_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;

    logic          full;
    logic          load;
    logic          push;
    logic          drain;
    logic          match;
    logic [DW-1:0] match_data;
    logic [PW-1:0] scan_idx;

    assign full  = (count_q == FULL_CNT);
    assign load  = MemRead & ~MemWrite;
    assign push  = MemWrite & ~full;
    // A stalled store frees a slot by draining, so push and pop never coincide.
    assign drain = (count_q != '0) & ~load & (~MemWrite | full);

    assign Stall   = MemWrite & full;
    assign Empty   = (count_q == '0);
    assign FwdHit  = fwd_hit_q;
    assign FwdData = fwd_data_q;

    // Scan oldest to youngest so the last valid match is the youngest store.
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[scan_idx] == Addr)) begin
                match      = 1'b1;
                match_data = data_q[scan_idx];
            end
        end
    end

    always_comb begin
        MemReadOut  = 1'b0;
        MemWriteOut = 1'b0;
        AddrOut     = '0;
        WdataOut    = '0;
        if (load) begin
            MemReadOut = 1'b1;
            AddrOut    = Addr;
        end else if (drain) begin
            MemWriteOut = 1'b1;
            AddrOut     = addr_q[head_q];
            WdataOut    = data_q[head_q];
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fwd_hit_d  = 1'b0;
        fwd_data_d = fwd_data_q;
        if (push) begin
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (drain) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
        end
        if (load) begin
            fwd_hit_d  = match;
            fwd_data_d = match_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Entry storage carries no reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= Addr;
            data_q[tail_q] <= Wdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus hand-written
// sequences for asynchronous reset and pointer wrap.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic        Stall;
    logic        MemWriteOut;
    logic        MemReadOut;
    logic [31:0] AddrOut;
    logic [31:0] WdataOut;
    logic        FwdHit;
    logic [31:0] FwdData;
    logic        Empty;

    int checks;
    int failures;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        mwo;
        logic        mro;
        logic [31:0] aout;
        logic [31:0] wout;
        logic        fh;
        logic [31:0] fd;
        logic        empty;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Addr       (Addr),
        .Wdata      (Wdata),
        .Stall      (Stall),
        .MemWriteOut(MemWriteOut),
        .MemReadOut (MemReadOut),
        .AddrOut    (AddrOut),
        .WdataOut   (WdataOut),
        .FwdHit     (FwdHit),
        .FwdData    (FwdData),
        .Empty      (Empty)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void add(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic stall, input logic mwo,
                                input logic mro, input logic [31:0] aout, input logic [31:0] wout,
                                input logic fh, input logic [31:0] fd, input logic empty);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
        v.stall = stall; v.mwo = mwo; v.mro = mro; v.aout = aout; v.wout = wout;
        v.fh = fh; v.fd = fd; v.empty = empty;
        vecs.push_back(v);
    endfunction

    // driver: apply inputs just after the rising edge, return at the falling edge
    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(posedge clk);
        #1;
        MemWrite = we;
        MemRead  = re;
        Addr     = addr;
        Wdata    = wdata;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".stall"}, {31'b0, Stall}, 32'd0);
        check({tag, ".mwo"},   {31'b0, MemWriteOut}, 32'd0);
        check({tag, ".mro"},   {31'b0, MemReadOut}, 32'd0);
        check({tag, ".aout"},  AddrOut, 32'd0);
        check({tag, ".wout"},  WdataOut, 32'd0);
        check({tag, ".fh"},    {31'b0, FwdHit}, 32'd0);
        check({tag, ".fd"},    FwdData, 32'd0);
        check({tag, ".empty"}, {31'b0, Empty}, 32'd1);
    endtask

    initial begin
        vec_t        v;
        logic [63:0] e;
        string       tag;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        Addr     = '0;
        Wdata    = '0;

        // single store, then idle
        add(1,0,5,'h11, 0,0,0,0,0,     0,0,1);
        add(0,0,0,0,    0,1,0,5,'h11,  0,0,0);
        add(0,0,0,0,    0,0,0,0,0,     0,0,1);
        // youngest match forwarded
        add(1,0,5,'h11, 0,0,0,0,0,     0,0,1);
        add(1,0,5,'h22, 0,0,0,0,0,     0,0,0);
        add(0,1,5,0,    0,0,1,5,0,     0,0,0);
        add(0,0,0,0,    0,1,0,5,'h11,  1,'h22,0);
        add(0,0,0,0,    0,1,0,5,'h22,  0,'h22,0);
        add(0,0,0,0,    0,0,0,0,0,     0,'h22,1);
        // load miss: no drain in the load cycle, data cleared to 0
        add(1,0,5,'h11, 0,0,0,0,0,     0,'h22,1);
        add(0,1,6,0,    0,0,1,6,0,     0,'h22,0);
        add(0,0,0,0,    0,1,0,5,'h11,  0,0,0);
        add(0,0,0,0,    0,0,0,0,0,     0,0,1);
        // full buffer (pointers already offset from zero)
        add(1,0,1,'h10, 0,0,0,0,0,     0,0,1);
        add(1,0,2,'h20, 0,0,0,0,0,     0,0,0);
        add(1,0,3,'h30, 0,0,0,0,0,     0,0,0);
        add(1,0,4,'h40, 0,0,0,0,0,     0,0,0);
        add(1,0,9,'h99, 1,1,0,1,'h10,  0,0,0);
        add(1,0,9,'h99, 0,0,0,0,0,     0,0,0);
        add(0,0,0,0,    0,1,0,2,'h20,  0,0,0);
        add(0,0,0,0,    0,1,0,3,'h30,  0,0,0);
        add(0,0,0,0,    0,1,0,4,'h40,  0,0,0);
        add(0,0,0,0,    0,1,0,9,'h99,  0,0,0);
        add(0,0,0,0,    0,0,0,0,0,     0,0,1);
        // read+write together is a store
        add(1,1,7,'h77, 0,0,0,0,0,     0,0,1);
        add(0,0,0,0,    0,1,0,7,'h77,  0,0,0);
        add(0,0,0,0,    0,0,0,0,0,     0,0,1);
        // youngest vs older match among mixed addresses, back-to-back loads
        add(1,0,3,'hA1, 0,0,0,0,0,     0,0,1);
        add(1,0,4,'hB1, 0,0,0,0,0,     0,0,0);
        add(1,0,3,'hC1, 0,0,0,0,0,     0,0,0);
        add(0,1,3,0,    0,0,1,3,0,     0,0,0);
        add(0,1,4,0,    0,0,1,4,0,     1,'hC1,0);
        add(0,0,0,0,    0,1,0,3,'hA1,  1,'hB1,0);
        add(0,0,0,0,    0,1,0,4,'hB1,  0,'hB1,0);
        add(0,0,0,0,    0,1,0,3,'hC1,  0,'hB1,0);
        add(0,0,0,0,    0,0,0,0,0,     0,'hB1,1);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.we, v.re, v.addr, v.wdata);
            tag = $sformatf("v%0d", i);
            check({tag, ".stall"}, {31'b0, Stall}, {31'b0, v.stall});
            check({tag, ".mwo"},   {31'b0, MemWriteOut}, {31'b0, v.mwo});
            check({tag, ".mro"},   {31'b0, MemReadOut}, {31'b0, v.mro});
            check({tag, ".aout"},  AddrOut, v.aout);
            check({tag, ".wout"},  WdataOut, v.wout);
            check({tag, ".fh"},    {31'b0, FwdHit}, {31'b0, v.fh});
            check({tag, ".fd"},    FwdData, v.fd);
            check({tag, ".empty"}, {31'b0, Empty}, {31'b0, v.empty});
        end

        // reset mid-operation: three pending stores plus a forwarding hit
        drive(1, 0, 7, 'hA);
        drive(1, 0, 8, 'hB);
        drive(1, 0, 9, 'hC);
        drive(0, 1, 7, 0);
        drive(0, 0, 0, 0);
        check("rst_pre.fh", {31'b0, FwdHit}, 32'd1);
        check("rst_pre.fd", FwdData, 32'hA);
        check("rst_pre.mwo", {31'b0, MemWriteOut}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0);
            check($sformatf("rst_idle%0d.mwo", i), {31'b0, MemWriteOut}, 32'd0);
            check($sformatf("rst_idle%0d.empty", i), {31'b0, Empty}, 32'd1);
        end

        // pointer wrap: ten store/idle pairs, scoreboard of expected retirements
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, i, 32'h100 + i);
            exp_q.push_back({32'(i), 32'h100 + 32'(i)});
            check($sformatf("wrap%0d.stall", i), {31'b0, Stall}, 32'd0);
            drive(0, 0, 0, 0);
            check($sformatf("wrap%0d.mwo", i), {31'b0, MemWriteOut}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("wrap%0d.aout", i), AddrOut, e[63:32]);
                check($sformatf("wrap%0d.wout", i), WdataOut, e[31:0]);
            end
        end
        drive(0, 0, 0, 0);
        check("wrap_end.empty", {31'b0, Empty}, 32'd1);
        check("wrap_end.pending", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write buffer between the EX/MEM pipeline register and `datamem`. It absorbs up to DEPTH pipeline stores and retires them to `datamem` in order on cycles when the pipeline makes no memory request. Loads go to `datamem` immediately and are checked against buffered stores; a matching store's data is forwarded one cycle later, aligned with `datamem`'s registered `Rdata`. A downstream MEM/WB mux picks `FwdData` over `Rdata` when `FwdHit`=1.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries; must be a power of 2, ≥2
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- MemWrite  in  1  pipeline store request this cycle
- MemRead  in  1  pipeline load request this cycle; ignored when MemWrite=1
- Addr  in  AW  word address of the request
- Wdata  in  DW  store data
- Stall  out  1  combinational; store not accepted this cycle, pipeline must hold
- MemWriteOut  out  1  write strobe to `datamem.MemWrite`
- MemReadOut  out  1  read strobe to `datamem.MemRead`
- AddrOut  out  AW  address to `datamem.Addr`
- WdataOut  out  DW  data to `datamem.Wdata`
- FwdHit  out  1  registered; the previous cycle's load matched a buffered entry
- FwdData  out  DW  registered; forwarded store data (valid when FwdHit=1)
- Empty  out  1  combinational; count==0

## Operation
- State:
  - circular FIFO of {addr, data}, DEPTH entries
  - head and tail pointers, log2(DEPTH) bits each, increment mod DEPTH (wrap naturally)
  - count, 0..DEPTH
- Full = (count==DEPTH).
- Stall = MemWrite & Full.
- Accept (push) = MemWrite & !Full. At the edge, entry[tail] ← {Addr, Wdata}; tail+1.
- Drain condition = count>0 & !(MemRead & !MemWrite) & (!MemWrite | Full):
  - drains on idle cycles and on stalled-store cycles
  - never drains during a load or an accepted store
- Port mux, by priority:
  1. Load (MemRead & !MemWrite): MemReadOut=1, AddrOut=Addr, MemWriteOut=0.
  2. Drain: MemWriteOut=1, AddrOut=entry[head].addr, WdataOut=entry[head].data. At the edge, head+1.
  3. Otherwise: all port outputs 0.
- Count update: count += push − pop. Push and pop never occur in the same cycle (a full stall pops; the retried store pushes next cycle).
- Forwarding on a load:
  - Addr is compared (full AW bits) against all valid entries.
  - The youngest matching entry wins (closest to tail).
  - At the edge, FwdHit ← match and FwdData ← matched data (0 when no match).
  - On non-load cycles, FwdHit ← 0 and FwdData holds its value.
- MemRead & MemWrite together: treated as a store only.
- Reset (async, any time):
  - head, tail and count ← 0
  - FwdHit ← 0, FwdData ← 0
  - pending stores are discarded and never written
  - entry storage need not be cleared

## Timing
- Reset values, with inputs at 0: Stall=0, MemWriteOut=0, MemReadOut=0, AddrOut=0, WdataOut=0, FwdHit=0, FwdData=0, Empty=1.
- Store acceptance: 0 cycles. The earliest retirement is the first qualifying cycle after the accepting edge.
- Store to full buffer: exactly 1 stall cycle. In that cycle the head drains; the held store is accepted the next cycle, unless a reset intervenes.
- Load forwarding latency: 1 cycle. FwdHit/FwdData are valid in the same cycle as `datamem.Rdata` for that load.
- Retirement order to `datamem` equals acceptance order, across pointer wrap.
- Port outputs are combinational from the inputs and head. No combinational path exists from the port outputs back to Stall.

## Test plan
- **Single store, then idle.** Reset; store Addr=5, Wdata=0x11; then idle. The idle cycle shows MemWriteOut=1, AddrOut=5, WdataOut=0x11; afterwards Empty=1.
- **Forward the youngest match.** Stores (5,0x11) and (5,0x22) back-to-back, then load Addr=5. The load cycle shows MemReadOut=1, AddrOut=5, MemWriteOut=0. The next cycle shows FwdHit=1, FwdData=0x22.
- **Load miss.** Store (5,0x11), then load Addr=6. The next cycle shows FwdHit=0, and no drain happens in the load cycle.
- **Full buffer.** Stores to addresses 1..4 back-to-back (DEPTH=4), then a 5th store (9,0x99) held.
  - Stall=1 for one cycle, with a drain of addr 1 in that cycle.
  - The 5th store is accepted the next cycle.
  - Idle drains then write 2, 3, 4, 9 in order.
- **Reset mid-operation.** Three pending stores; reset is asserted between edges. All outputs reach their reset values immediately, and no MemWriteOut pulse follows.
- **Pointer wrap.** Ten stores, each followed by an idle cycle, with addresses 0..9. Drains occur in the same order with correct data, and head/tail wrap past DEPTH without loss.
